// File: rtl/opl_reg_uart_tx.sv
// -----------------------------------------------------------------------------
// opl_reg_uart_tx
//
// Host-side serializer for the OPL2 register-write serial link. Register
// writes arrive as (addr, data) pairs over a valid/ready handshake, are
// buffered in a small FIFO and sent as two 8N1 UART bytes (address first,
// then data). Whenever the queue drains, and after reset, the line is held
// idle for an end-of-packet gap so the receiver's address/data toggle
// re-aligns before the next pair.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high
//   wr_valid    a register-write pair is offered
//   wr_ready    FIFO can accept a pair (count < FIFO_DEPTH)
//   wr_addr     OPL register address
//   wr_data     OPL register data
//   TxD         serial output, idle high, registered
//   busy        FSM not idle or FIFO non-empty
//   fifo_count  number of pairs currently queued
// -----------------------------------------------------------------------------
module opl_reg_uart_tx #(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int FIFO_DEPTH   = 4,
    parameter int EOP_GAP_BITS = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [7:0]                          wr_addr,
    input  logic [7:0]                          wr_data,
    output logic                                TxD,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    // Bit period rounded to the nearest whole clock.
    localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int GAP_CLKS = EOP_GAP_BITS * DIV;
    localparam int BAUD_W   = $clog2(DIV + 1);
    localparam int GAP_W    = $clog2(GAP_CLKS + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);

    typedef enum logic [2:0] {
        GAP   = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [BAUD_W-1:0]  baud_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [2:0]         bit_idx_r;
    logic [7:0]         shift_r;
    logic [7:0]         data_hold_r;
    logic               addr_phase_r;
    logic               txd_r;

    logic [7:0]         addr_mem_r [FIFO_DEPTH];
    logic [7:0]         data_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               push_s;
    logic               pop_s;
    logic               load_addr_s;
    logic               load_data_s;
    logic               fifo_empty_s;
    logic               bit_end_s;
    logic               gap_end_s;
    logic               last_bit_s;
    logic               wr_ready_s;

    // Handshake and status decode; all derived from registered state only.
    assign wr_ready_s   = (count_r < CNT_FULL);
    assign fifo_empty_s = (count_r == CNT_ZERO);
    assign push_s       = wr_valid && wr_ready_s;
    assign bit_end_s    = (baud_cnt_r == BAUD_LAST);
    assign gap_end_s    = (gap_cnt_r == GAP_LAST);
    assign last_bit_s   = (bit_idx_r == 3'd7);

    assign wr_ready   = wr_ready_s;
    assign busy       = (state_r != IDLE) || !fifo_empty_s;
    assign fifo_count = count_r;
    assign TxD        = txd_r;

    // FSM state register; reset lands in GAP so the link resynchronizes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= GAP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and pop/load strobes.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        load_addr_s = 1'b0;
        load_data_s = 1'b0;
        case (state_r)
            GAP: begin
                if (gap_end_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    load_addr_s = 1'b1;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && last_bit_s) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (addr_phase_r) begin
                        // Data byte follows its address with no idle time.
                        load_data_s = 1'b1;
                        state_nxt_s = START;
                    end else if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        load_addr_s = 1'b1;
                        state_nxt_s = START;
                    end else begin
                        state_nxt_s = GAP;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = GAP;
            end
        endcase
    end

    // Baud counter: runs only while a frame is on the wire, restarts each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_r <= '0;
        end else if ((state_r == START) || (state_r == DATA) || (state_r == STOP)) begin
            if (bit_end_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_ONE;
            end
        end else begin
            baud_cnt_r <= '0;
        end
    end

    // End-of-packet gap counter; held at zero outside GAP and during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_r <= '0;
        end else if (state_r == GAP) begin
            if (gap_end_s) begin
                gap_cnt_r <= '0;
            end else begin
                gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end
        end else begin
            gap_cnt_r <= '0;
        end
    end

    // Data bit index within the current byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_r <= 3'd0;
        end else if (state_r == DATA) begin
            if (bit_end_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end
        end else begin
            bit_idx_r <= 3'd0;
        end
    end

    // Byte shifter: loads address (holding data aside) or data, shifts LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r      <= 8'h00;
            data_hold_r  <= 8'h00;
            addr_phase_r <= 1'b0;
        end else if (load_addr_s) begin
            shift_r      <= addr_mem_r[rd_ptr_r];
            data_hold_r  <= data_mem_r[rd_ptr_r];
            addr_phase_r <= 1'b1;
        end else if (load_data_s) begin
            shift_r      <= data_hold_r;
            addr_phase_r <= 1'b0;
        end else if ((state_r == DATA) && bit_end_s) begin
            shift_r      <= {1'b0, shift_r[7:1]};
        end else begin
            shift_r      <= shift_r;
        end
    end

    // Serial output register; lags the FSM by one clock, so each level
    // lasts exactly one bit period and only changes at bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_r <= 1'b1;
        end else begin
            case (state_r)
                START:   txd_r <= 1'b0;
                DATA:    txd_r <= shift_r[0];
                default: txd_r <= 1'b1;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem_r[i] <= 8'h00;
                data_mem_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            addr_mem_r[wr_ptr_r] <= wr_addr;
            data_mem_r[wr_ptr_r] <= wr_data;
        end else begin
            addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers; depth is a power of two so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_opl_reg_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_opl_reg_uart_tx
//
// Self-checking bench for opl_reg_uart_tx. A faster baud rate keeps run time
// short: CLK_HZ=27 MHz, BAUD=1.125 MHz gives a bit period of 24 clocks
// ((27000000 + 562500) / 1125000 = 24.5 -> 24) and a 24*24 = 576 clock gap.
// Accepted pairs are pushed to a byte scoreboard; a line monitor decodes
// TxD at mid-bit and pops/compares each received byte.
// -----------------------------------------------------------------------------
module tb_opl_reg_uart_tx;

    localparam int DIV  = 24;
    localparam int GAP  = 576;
    localparam int HALF = DIV / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       TxD;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_bytes = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];

    int         mon_state = 0;
    int         mon_cnt = 0;
    int         mon_k = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] exp_b;

    opl_reg_uart_tx #(
        .CLK_HZ      (27000000),
        .BAUD        (1125000),
        .FIFO_DEPTH  (4),
        .EOP_GAP_BITS(24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .TxD       (TxD),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: sample just after each negedge, decode 8N1 at mid-bit.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            mon_state = 0;
        end else if (mon_state == 0) begin
            if (TxD == 1'b0) begin
                mon_state = 1;
                mon_cnt   = 0;
                starts_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % DIV) == HALF) begin
                mon_k = mon_cnt / DIV;
                if (mon_k == 0) begin
                    checks++;
                    if (TxD !== 1'b0) begin
                        errors++;
                        $display("FAIL start_bit got %b want 0 at cyc %0d", TxD, cyc);
                    end
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = TxD;
                end else begin
                    checks++;
                    if (TxD !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit got %b want 1 at cyc %0d", TxD, cyc);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte got %02h want nothing", mon_byte);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (mon_byte !== exp_b) begin
                            errors++;
                            $display("FAIL rx_byte got %02h want %02h", mon_byte, exp_b);
                        end
                    end
                    rx_bytes++;
                    mon_state = 0;
                end
            end
        end
    end

    // Offer one pair from the current negedge until accepted; returns accept edge.
    task automatic push_pair(input logic [7:0] a, input logic [7:0] d, output int acc);
        int guard;
        guard    = 0;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        while (!wr_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got ready=%b want 1", wr_ready);
            wr_valid = 1'b0;
            acc      = -1;
        end else begin
            acc = cyc + 1;
            exp_q.push_back(a);
            exp_q.push_back(d);
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || mon_state != 0) && g < budget) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (exp_q.size() != 0 || mon_state != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d bytes pending want 0", exp_q.size());
        end
    endtask

    task automatic wait_idle(input int budget);
        int g;
        g = 0;
        while (busy !== 1'b0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset;
        int k;
        int lows;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", TxD); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", wr_ready); end
        rst  = 1'b0;
        k    = 0;
        lows = 0;
        while (busy !== 1'b0 && k < GAP + 200) begin
            @(negedge clk);
            k++;
            if (TxD !== 1'b1) lows++;
        end
        checks++; if (k != GAP) begin errors++; $display("FAIL rst_gap_len got %0d want %0d", k, GAP); end
        checks++; if (lows != 0) begin errors++; $display("FAIL rst_gap_txd got %0d low clocks want 0", lows); end
    endtask

    task automatic test_single;
        int acc;
        int rx0;
        starts_q.delete();
        rx0 = rx_bytes;
        push_pair(8'hA0, 8'h41, acc);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", fifo_count); end
        @(negedge clk);
        checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL single_lat_n1 got %b want 1", TxD); end
        @(negedge clk);
        checks++; if (TxD !== 1'b0) begin errors++; $display("FAIL single_lat_n2 got %b want 0", TxD); end
        wait_drain(30 * DIV);
        checks++; if (rx_bytes - rx0 != 2) begin errors++; $display("FAIL single_bytes got %0d want 2", rx_bytes - rx0); end
        checks++;
        if (starts_q.size() != 2) begin
            errors++;
            $display("FAIL single_frames got %0d want 2", starts_q.size());
        end else begin
            checks++; if (starts_q[0] != acc + 2) begin errors++; $display("FAIL single_start got %0d want %0d", starts_q[0], acc + 2); end
            checks++; if (starts_q[1] - starts_q[0] != 10 * DIV) begin errors++; $display("FAIL single_spacing got %0d want %0d", starts_q[1] - starts_q[0], 10 * DIV); end
        end
    endtask

    // Runs straight after test_single, while its end-of-packet gap is underway.
    task automatic test_gap_push;
        int acc;
        int s2;
        int gap_begin;
        s2        = (starts_q.size() >= 2) ? starts_q[1] : cyc;
        gap_begin = s2 - 1 + 10 * DIV;
        wait_until(gap_begin + 99);
        push_pair(8'h3C, 8'hC3, acc);
        checks++; if (acc != gap_begin + 100) begin errors++; $display("FAIL gap_push_edge got %0d want %0d", acc, gap_begin + 100); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL gap_queued got %0d want 1", fifo_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy got %b want 1", busy); end
        starts_q.delete();
        wait_drain(GAP + 30 * DIV);
        checks++;
        if (starts_q.size() < 1) begin
            errors++;
            $display("FAIL gap_frames got %0d want 2", starts_q.size());
        end else if (starts_q[0] != s2 + 10 * DIV + GAP + 1) begin
            errors++;
            $display("FAIL gap_start got %0d want %0d", starts_q[0], s2 + 10 * DIV + GAP + 1);
        end
    endtask

    task automatic test_back_to_back;
        int acc1;
        int acc;
        int bad;
        int lows;
        int s6;
        wait_idle(GAP + 30 * DIV);
        starts_q.delete();
        push_pair(8'h11, 8'h22, acc1);
        push_pair(8'h33, 8'h44, acc);
        push_pair(8'h55, 8'h66, acc);
        wait_drain(70 * DIV);
        checks++;
        if (starts_q.size() != 6) begin
            errors++;
            $display("FAIL burst_frames got %0d want 6", starts_q.size());
        end else begin
            checks++; if (starts_q[0] != acc1 + 2) begin errors++; $display("FAIL burst_start got %0d want %0d", starts_q[0], acc1 + 2); end
            bad = 0;
            for (int i = 1; i < 6; i++) begin
                if (starts_q[i] - starts_q[i-1] != 10 * DIV) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL burst_contiguous got %0d gaps want 0", bad); end
            s6   = starts_q[5];
            lows = 0;
            while (busy !== 1'b0 && cyc < s6 + 10 * DIV + GAP + 200) begin
                @(negedge clk);
                if (TxD !== 1'b1) lows++;
            end
            checks++; if (cyc != s6 + 10 * DIV + GAP - 1) begin errors++; $display("FAIL burst_idle_at got %0d want %0d", cyc, s6 + 10 * DIV + GAP - 1); end
            checks++; if (lows != 0) begin errors++; $display("FAIL burst_gap_txd got %0d low clocks want 0", lows); end
        end
    endtask

    task automatic test_backpressure;
        int acc1;
        int acc;
        int acc6;
        int rx0;
        wait_idle(GAP + 30 * DIV);
        rx0 = rx_bytes;
        push_pair(8'h01, 8'h81, acc1);
        push_pair(8'h02, 8'h82, acc);
        push_pair(8'h03, 8'h83, acc);
        push_pair(8'h04, 8'h84, acc);
        push_pair(8'h05, 8'h85, acc);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d want 4", fifo_count); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", wr_ready); end
        push_pair(8'h06, 8'h86, acc6);
        checks++; if (acc6 != acc1 + 2 + 20 * DIV) begin errors++; $display("FAIL bp_accept_edge got %0d want %0d", acc6, acc1 + 2 + 20 * DIV); end
        wait_drain(130 * DIV);
        checks++; if (rx_bytes - rx0 != 12) begin errors++; $display("FAIL bp_bytes got %0d want 12", rx_bytes - rx0); end
    endtask

    task automatic test_same_cycle;
        int acc1;
        int acc;
        int e;
        int rx0;
        wait_idle(GAP + 30 * DIV);
        rx0 = rx_bytes;
        push_pair(8'h21, 8'hA1, acc1);
        push_pair(8'h22, 8'hA2, acc);
        push_pair(8'h23, 8'hA3, acc);
        e = acc1 + 1 + 20 * DIV;
        wait_until(e - 1);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL same_pre_count got %0d want 2", fifo_count); end
        wr_addr  = 8'h24;
        wr_data  = 8'hA4;
        wr_valid = 1'b1;
        exp_q.push_back(8'h24);
        exp_q.push_back(8'hA4);
        @(negedge clk);
        wr_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL same_post_count got %0d want 2", fifo_count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b want 1", wr_ready); end
        wait_drain(90 * DIV);
        checks++; if (rx_bytes - rx0 != 8) begin errors++; $display("FAIL same_bytes got %0d want 8", rx_bytes - rx0); end
    endtask

    task automatic test_reset_mid;
        int acc;
        int s;
        int k;
        int lows;
        int g;
        int rx0;
        starts_q.delete();
        push_pair(8'h00, 8'h5A, acc);
        push_pair(8'h12, 8'h34, acc);
        g = 0;
        while (starts_q.size() == 0 && g < GAP + 30 * DIV) begin
            @(negedge clk);
            g++;
        end
        s = (starts_q.size() > 0) ? starts_q[0] : cyc;
        wait_until(s + 4 * DIV + HALF);
        checks++; if (TxD !== 1'b0) begin errors++; $display("FAIL mid_pre_txd got %b want 0", TxD); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mid_pre_count got %0d want 1", fifo_count); end
        rst = 1'b1;
        exp_q.delete();
        starts_q.delete();
        @(negedge clk);
        checks++; if (TxD !== 1'b1) begin errors++; $display("FAIL mid_txd got %b want 1", TxD); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst  = 1'b0;
        k    = 0;
        lows = 0;
        while (busy !== 1'b0 && k < GAP + 200) begin
            @(negedge clk);
            k++;
            if (TxD !== 1'b1) lows++;
        end
        checks++; if (k != GAP) begin errors++; $display("FAIL mid_gap_len got %0d want %0d", k, GAP); end
        checks++; if (lows != 0) begin errors++; $display("FAIL mid_gap_txd got %0d low clocks want 0", lows); end
        rx0 = rx_bytes;
        push_pair(8'hC3, 8'h96, acc);
        wait_drain(30 * DIV);
        checks++; if (rx_bytes - rx0 != 2) begin errors++; $display("FAIL mid_after_bytes got %0d want 2", rx_bytes - rx0); end
        checks++;
        if (starts_q.size() < 1) begin
            errors++;
            $display("FAIL mid_after_frames got %0d want 2", starts_q.size());
        end else if (starts_q[0] != acc + 2) begin
            errors++;
            $display("FAIL mid_after_start got %0d want %0d", starts_q[0], acc + 2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap_push();
        test_back_to_back();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got cyc=%0d want completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
